serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor; successor to the combinational half-subtractor cell.
- Computes diff = a - b on WIDTH-bit unsigned operands, CHUNK bits per clock, with a registered borrow chained between chunks.
- Used where a full-width ripple subtractor is too large or too slow. Start/done handshake to a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- CHUNK, 1, bits processed per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails via a generate-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid.
- diff  output  WIDTH  result a - b mod 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  final borrow; 1 iff a < b unsigned; held with diff.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- One clock, named clk. Reset is synchronous and active-high, named rst.
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0, ovf=0.
  - Internal shift registers, chunk counter and borrow register cleared.
  - Applies from any state, including mid-RUN; a partial result is discarded and done is not asserted.
- N = WIDTH/CHUNK. Counter width is clog2(N+1).
- States:
  - IDLE: start=1 → load a_sh=a, b_sh=b, borrow register=0, count=0, go to RUN.
  - RUN, one chunk per edge:
    - {br, d} = a_sh[CHUNK-1:0] - b_sh[CHUNK-1:0] - borrow.
    - d is shifted into the MSB end of the result shift register.
    - a_sh and b_sh shift right by CHUNK. borrow ← br. count++.
    - When count reaches N-1 on this edge, go to DONE.
    - Latch diff from the result register and borrow_out from br.
  - DONE: done=1 for exactly this cycle. start=1 → accept as in IDLE (back-to-back ops); else go to IDLE.
- Timing: start accepted at edge E0. busy=1 in cycles after E0..E(N-1). done=1 in the cycle after EN. Latency is N+1 edges.
- busy and done are never high in the same cycle.
- start while busy=1 is ignored; a and b are not re-sampled.
- diff and borrow_out change only on the edge entering DONE, or on rst.
- CHUNK=WIDTH degenerates to a single RUN cycle, giving 2-edge latency.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists.
  - Latched on entry to DONE as (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured MSBs.
  - Cleared on rst; held with diff.
- Undefined: no ovf port and no associated logic; all other behaviour identical.

Decomposition:
- Package serial_sub_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a clog2 function for counter sizing.
- Sub-module chunk_sub (parameter CHUNK):
  - combinational CHUNK-bit borrow-ripple subtractor, inputs a, b, bin; outputs d, bout;
  - built as a chain of half/full subtractor cells and instantiated once in the datapath.

Test Plan:
- WIDTH=8, CHUNK=1: a=0x5A, b=0x3C, start pulse → busy for 8 cycles, done on cycle 9; diff=0x1E, borrow_out=0.
- WIDTH=8, CHUNK=1: a=0x00, b=0x01 → diff=0xFF, borrow_out=1; values held 5 cycles after done with start=0.
- WIDTH=8, CHUNK=4: a=0x10, b=0x01 → done on cycle 3 after start; diff=0x0F, borrow_out=0.
- Start again with a=0x22, b=0x11 while busy → ignored; first result unchanged. Start during done with a=0x22, b=0x11 → diff=0x11 after N+1 edges, with no IDLE cycle in between.
- rst asserted at RUN cycle 4 → next cycle busy=0, done=0, diff=0; no done pulse follows. A fresh op 0x0F-0x0F then gives diff=0x00, borrow_out=0.
- SERIAL_SUB_OVF_EN defined, WIDTH=8: 0x80-0x01 → diff=0x7F, ovf=1; 0x05-0x03 → diff=0x02, ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared state encoding and sizing helper for the serial subtractor.
package serial_sub_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_chunk_sub.sv
// Combinational CHUNK-bit borrow-ripple subtractor: {bout, d} = a - b - bin.
module chunk_sub #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] bw;

  assign bw[0] = bin;

  // Each cell is a half subtractor on a/b followed by a second stage folding in the borrow.
  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    logic hd;
    logic hb;
    assign hd        = a[i] ^ b[i];
    assign hb        = ~a[i] & b[i];
    assign d[i]      = hd ^ bw[i];
    assign bw[i+1]   = hb | (~hd & bw[i]);
  end

  assign bout = bw[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor, CHUNK bits per clock with a registered inter-chunk borrow.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("serial_subtractor: WIDTH must be a positive multiple of CHUNK");
  end

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = clog2(N + 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q, bout_q;
  logic [CHUNK-1:0] chunk_d;
  logic             chunk_bout;
  logic [WIDTH-1:0] res_next;
  logic             accept, last;

  chunk_sub #(.CHUNK(CHUNK)) u_chunk_sub (
    .a    (a_sh_q[CHUNK-1:0]),
    .b    (b_sh_q[CHUNK-1:0]),
    .bin  (brw_q),
    .d    (chunk_d),
    .bout (chunk_bout)
  );

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last     = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));
  // New chunk enters at the MSB end so the LSB chunk ends up at bit 0 after N shifts.
  assign res_next = (res_q >> CHUNK) | (WIDTH'(chunk_d) << (WIDTH - CHUNK));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (last) begin
      ovf_q <= (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_sh_q <= a;
      b_sh_q <= b;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      a_sh_q <= a_sh_q >> CHUNK;
      b_sh_q <= b_sh_q >> CHUNK;
      res_q  <= res_next;
      brw_q  <= chunk_bout;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        diff_q <= res_next;
        bout_q <= chunk_bout;
      end
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of serial_subtractor with CHUNK=1 and CHUNK=4 instances at WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy1, done1, bout1, busy4, done4, bout4;
  logic [7:0] diff1, diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf1, ovf4;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .a          (a),
    .b          (b),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (bout1)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf1)
`endif
  );

  serial_subtractor #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .a          (a),
    .b          (b),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (bout4)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Starts an op on the CHUNK=1 instance and returns edges until done (bounded).
  task automatic run1(input logic [7:0] aa, input logic [7:0] bb, output int lat);
    a      = aa;
    b      = bb;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat    = 1;
    while (!done1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;

    // Reset state
    tick();
    tick();
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_diff1", diff1, 8'h00);
    chk("rst_bout1", bout1, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_diff4", diff4, 8'h00);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf1", ovf1, 0);
`endif
    rst = 1'b0;
    tick();

    // 0x5A - 0x3C, CHUNK=1: 8 busy cycles, done on the 9th; start while busy ignored
    a = 8'h5A; b = 8'h3C; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy1 && !done1) seen++;
      if (i == 3) begin
        a = 8'h22; b = 8'h11; start1 = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      tick();
    end
    start1 = 1'b0;
    chk("op1_busy_cycles", seen, 8);
    chk("op1_done", done1, 1);
    chk("op1_busy_at_done", busy1, 0);
    chk("op1_diff", diff1, 8'h1E);
    chk("op1_bout", bout1, 0);
    tick();
    chk("op1_done_pulse", done1, 0);
    chk("op1_diff_held", diff1, 8'h1E);

    // 0x00 - 0x01 -> 0xFF with borrow, held 5 cycles after done
    run1(8'h00, 8'h01, lat);
    chk("op2_latency", lat, 9);
    chk("op2_diff", diff1, 8'hFF);
    chk("op2_bout", bout1, 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (diff1 === 8'hFF && bout1 === 1'b1 && !done1 && !busy1) seen++;
    end
    chk("op2_hold", seen, 5);

    // CHUNK=4: 0x10 - 0x01 done on cycle 3, then back-to-back 0x22 - 0x11
    a = 8'h10; b = 8'h01; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("op3_busy_c1", busy4, 1);
    tick();
    chk("op3_busy_c2", busy4, 1);
    tick();
    chk("op3_done", done4, 1);
    chk("op3_diff", diff4, 8'h0F);
    chk("op3_bout", bout4, 0);
    a = 8'h22; b = 8'h11; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("b2b_busy_no_idle", busy4, 1);
    chk("b2b_done_low", done4, 0);
    chk("b2b_diff_held", diff4, 8'h0F);
    tick();
    chk("b2b_busy_c2", busy4, 1);
    tick();
    chk("b2b_done", done4, 1);
    chk("b2b_diff", diff4, 8'h11);
    chk("b2b_bout", bout4, 0);
    tick();

    // Reset during RUN cycle 4 of the CHUNK=1 instance
    a = 8'h33; b = 8'h11; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy_c4", busy1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_diff1", diff1, 8'h00);
    chk("mid_rst_bout1", bout1, 0);
    chk("mid_rst_diff4", diff4, 8'h00);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1 || busy1) seen++;
    end
    chk("mid_rst_quiet", seen, 0);

    run1(8'h0F, 8'h0F, lat);
    chk("fresh_latency", lat, 9);
    chk("fresh_diff", diff1, 8'h00);
    chk("fresh_bout", bout1, 0);
    tick();

    run1(8'h3C, 8'h5A, lat);
    chk("neg_diff", diff1, 8'hE2);
    chk("neg_bout", bout1, 1);
    tick();

`ifdef SERIAL_SUB_OVF_EN
    run1(8'h80, 8'h01, lat);
    chk("ovf_a_diff", diff1, 8'h7F);
    chk("ovf_a_ovf", ovf1, 1);
    tick();
    run1(8'h05, 8'h03, lat);
    chk("ovf_b_diff", diff1, 8'h02);
    chk("ovf_b_ovf", ovf1, 0);
    tick();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
